// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32-style ALU with valid/ready handshakes on both sides.
// Single-cycle ops (0-9) produce a result one cycle after accept; multiply and
// divide iterate one bit per cycle through a shared 2*WIDTH accumulator.
// Optional build macro ALU_MC_SIGNED_MULDIV_EN enables OP 14 (DIV) and OP 15
// (REM), signed, via magnitude division plus sign correction.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] R,
  output logic             BUSY
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;   // mul: {high, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opd_q, opd_d;   // multiplicand or divisor
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
`ifdef ALU_MC_SIGNED_MULDIV_EN
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
`endif
  logic               accept;

  // Single-cycle operations; undefined codes return zero.
  function automatic logic [WIDTH-1:0] alu_single(input logic [3:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    sa = a;
    sb = b;
    sh = b[SHW-1:0];
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return sa >>> sh;
      4'd8:    return {{(WIDTH-1){1'b0}}, (sa < sb)};
      4'd9:    return {{(WIDTH-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_MC_SIGNED_MULDIV_EN
    return op >= 4'd10;
`else
    return (op >= 4'd10) && (op <= 4'd13);
`endif
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == 4'd10) || (op == 4'd11);
  endfunction

  // One shift-add step: conditionally add multiplicand to the high half, shift right.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] mcand);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

  // One restoring-divide step; divisor zero naturally yields all-ones quotient
  // and a remainder equal to the dividend.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, dvsr};
    if (!diff[WIDTH]) return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else              return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

`ifdef ALU_MC_SIGNED_MULDIV_EN
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                  input logic neg);
    return neg ? -mag : mag;
  endfunction
`endif

  assign accept    = IN_VALID && IN_READY;
  assign OUT_VALID = (state_q == S_DONE);
  assign BUSY      = (state_q == S_BUSY);
  assign R         = r_q;

  // Ready is combinational so a finished result can retire while the next op enters.
  always_comb begin
    IN_READY = (state_q == S_IDLE) || ((state_q == S_DONE) && OUT_READY);
  end

  // Next-state, operand loading and iterative datapath.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    acc_d   = acc_q;
    opd_d   = opd_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
`ifdef ALU_MC_SIGNED_MULDIV_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      S_BUSY: begin
        acc_d = is_mul(op_q) ? mul_step(acc_q, opd_q) : div_step(acc_q, opd_q);
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          case (op_q)
            4'd11, 4'd13: r_d = acc_d[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_SIGNED_MULDIV_EN
            4'd14:        r_d = apply_sign(acc_d[WIDTH-1:0], negq_q);
            4'd15:        r_d = apply_sign(acc_d[2*WIDTH-1:WIDTH], negr_q);
`endif
            default:      r_d = acc_d[WIDTH-1:0];
          endcase
        end
      end
      default: begin
        if (accept) begin
          op_d = OP;
          if (is_iter(OP)) begin
            state_d = S_BUSY;
            cnt_d   = SHW'(WIDTH - 1);
            if (is_mul(OP)) begin
              acc_d = {{WIDTH{1'b0}}, B};
              opd_d = A;
`ifdef ALU_MC_SIGNED_MULDIV_EN
            end else if (OP >= 4'd14) begin
              acc_d  = {{WIDTH{1'b0}}, magnitude(A)};
              opd_d  = magnitude(B);
              negq_d = (A[WIDTH-1] ^ B[WIDTH-1]) && (B != '0);
              negr_d = A[WIDTH-1];
`endif
            end else begin
              acc_d = {{WIDTH{1'b0}}, A};
              opd_d = B;
            end
          end else begin
            state_d = S_DONE;
            r_d     = alu_single(OP, A, B);
          end
        end else if ((state_q == S_DONE) && OUT_READY) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      acc_q   <= '0;
      opd_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
`ifdef ALU_MC_SIGNED_MULDIV_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      acc_q   <= acc_d;
      opd_q   <= opd_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
`ifdef ALU_MC_SIGNED_MULDIV_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc (WIDTH=32): directed steps plus randomized ops checked
// against an arithmetic reference model.
module tb_alu_mc;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  OP;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] R;
  logic        BUSY;

  int n_tests = 0;
  int n_fail  = 0;

  alu_mc #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OP(OP), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .R(R), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference result from plain arithmetic on the operation's definition.
  function automatic logic [31:0] ref_result(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    longint unsigned p;
    int sa;
    int sb;
    int sh;
    p  = 64'(a) * 64'(b);
    sa = a;
    sb = b;
    sh = int'(b[4:0]);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return sa >>> sh;
      4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
`ifdef ALU_MC_SIGNED_MULDIV_EN
      4'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      4'd15: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
`ifdef ALU_MC_SIGNED_MULDIV_EN
    return (op >= 4'd10) ? 33 : 1;
`else
    return (op >= 4'd10 && op <= 4'd13) ? 33 : 1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op with OUT_READY=1, measure latency, check result, retire it.
  // Called at posedge+1.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int cyc;
    int lat;
    lat = ref_lat(op);
    OUT_READY = 1'b1;
    cyc = 0;
    while (!IN_READY && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
    IN_VALID = 1'b1; OP = op; A = a; B = b;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; OP = 4'($urandom); A = $urandom; B = $urandom;
    if (lat > 1) begin
      chk({tag, "_busy"}, 32'(BUSY), 32'd1);
      chk({tag, "_inrdy"}, 32'(IN_READY), 32'd0);
    end
    cyc = 1;
    while (!OUT_VALID && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk(tag, R, exp);
    @(posedge CLK); #1;
  endtask

  logic [31:0] bb_exp [10];
  logic [31:0] hold_r;
  logic [3:0]  rop;
  logic [31:0] ra;
  logic [31:0] rb;
  int          cyc;

  initial begin
    bb_exp = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0002, 32'hFFFF_FFFE, 32'hFFFF_FFFC,
               32'hFFFF_FFF8, 32'h3FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};

    // Reset state
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0; OP = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_r", R, 32'd0);
    chk("rst_ovalid", 32'(OUT_VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    #1;
    chk("rst_inrdy", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;

    // Back-to-back single-cycle ops, no bubbles
    OUT_READY = 1'b1;
    IN_VALID = 1'b1; A = 32'hFFFF_FFFE; B = 32'd2;
    for (int i = 0; i < 10; i++) begin
      OP = 4'(i);
      @(posedge CLK); #1;
      chk($sformatf("b2b_vld%0d", i), 32'(OUT_VALID), 32'd1);
      chk($sformatf("b2b_r%0d", i), R, bb_exp[i]);
      chk($sformatf("b2b_model%0d", i), R, ref_result(4'(i), 32'hFFFF_FFFE, 32'd2));
    end
    IN_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("b2b_idle", 32'(OUT_VALID), 32'd0);

    // Multiply / divide directed cases
    run_op("mul",     4'd10, 32'd7,          32'd6,          32'd42);
    run_op("mulhu",   4'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
    run_op("divu",    4'd12, 32'd100,        32'd7,          32'd14);
    run_op("remu",    4'd13, 32'd100,        32'd7,          32'd2);
    run_op("divu_z",  4'd12, 32'd5,          32'd0,          32'hFFFF_FFFF);
    run_op("remu_z",  4'd13, 32'd5,          32'd0,          32'd5);
`ifdef ALU_MC_SIGNED_MULDIV_EN
    run_op("div_s",   4'd14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    run_op("rem_s",   4'd15, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    run_op("div_ovf", 4'd14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    run_op("rem_ovf", 4'd15, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
    run_op("div_z",   4'd14, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF);
`else
    run_op("op14_undef", 4'd14, 32'hFFFF_FFF9, 32'd2, 32'd0);
    run_op("op15_undef", 4'd15, 32'd100,       32'd7, 32'd0);
`endif

    // Backpressure: result held while OUT_READY=0, then retire + accept together
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; OP = 4'd0; A = 32'h10; B = 32'h20;
    @(posedge CLK); #1;
    OP = 4'd4; A = 32'hF0F0_0000; B = 32'h0FF0_1234;
    hold_r = R;
    chk("bp_first", R, 32'h30);
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("bp_r%0d", i), R, 32'h30);
      chk($sformatf("bp_vld%0d", i), 32'(OUT_VALID), 32'd1);
      chk($sformatf("bp_inrdy%0d", i), 32'(IN_READY), 32'd0);
    end
    OUT_READY = 1'b1;
    #1;
    chk("bp_inrdy_up", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    chk("bp_new_vld", 32'(OUT_VALID), 32'd1);
    chk("bp_new_r", R, 32'hFF00_1234);
    @(posedge CLK); #1;

    // Reset in the middle of a DIVU
    IN_VALID = 1'b1; OP = 4'd12; A = 32'd1000; B = 32'd3;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (10) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("mid_rst_vld", 32'(OUT_VALID), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    chk("mid_rst_r", R, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("post_rst_inrdy", 32'(IN_READY), 32'd1);
    @(posedge CLK); #1;
    run_op("post_rst_add", 4'd0, 32'd3, 32'd4, 32'd7);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, ref_result(rop, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
